spi_master: RTL
===============

Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames, single slave select.
- Drives the FPGA SPI slave port (SCK/MOSI/MISO/SSEL) from fabric logic.
- Used for loopback bring-up of the SPI slave path and for talking to external SPI peripherals.
- Byte-level valid/ready handshake in, one-cycle pulse out; multi-byte messages are framed by tx_last.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period; legal range 2..255.
- CS_SETUP, 4: clk cycles SSEL is low before the first SCK rising edge.
- CS_HOLD, 4: clk cycles after the last SCK falling edge before SSEL goes high.
- CS_IDLE, 8: minimum clk cycles SSEL stays high between messages.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_last  in  1  qualifies tx_data; 1 = final byte of the message
- tx_valid  in  1  byte offered
- tx_ready  out  1  master accepts tx_data this cycle
- rx_data  out  8  byte received on MISO; held until the next rx_valid
- rx_valid  out  1  one-cycle pulse, rx_data is new
- busy  out  1  SSEL asserted, or in CS_IDLE gap
- SCK  out  1  serial clock; idle low
- MOSI  out  1  serial data out
- MISO  in  1  serial data in; asynchronous, 2-FF synchronised internally
- SSEL  out  1  slave select, active low

Behaviour:
- All outputs are registered.
- Reset values: SCK=0, SSEL=1, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0. State is IDLE on the cycle after rst deasserts.
- rst mid-transfer: abort immediately. SSEL=1 and SCK=0 on the next edge; no rx_valid; the byte in flight is lost.
- States:
  - IDLE: tx_ready=1. On tx_valid&tx_ready, latch tx_data into shreg and tx_last into a last flag, then go to SETUP.
  - SETUP: SSEL=0, MOSI=shreg[7]. Count CS_SETUP cycles, then go to HI.
  - HI: SCK=1 for CLK_DIV cycles. On the last cycle, shift the synchronised MISO into rxreg (LSB-in, left shift). Go to LO.
  - LO: SCK=0 for CLK_DIV cycles.
    - After the 8th HI phase: rx_data<=rxreg and rx_valid=1 for one cycle at LO entry.
    - At LO entry for bits 1..7: MOSI<=next bit.
    - Bit counter 3 bits; wraps to 0 after bit 7.
    - At end of the LO phase of bit 7: if last, go to HOLD; else go to NEXT.
  - NEXT: SSEL stays 0, SCK=0, tx_ready=1, waits indefinitely. On handshake, latch data and last flag, MOSI=data[7], go to HI after CLK_DIV cycles (LO-length setup).
  - HOLD: SSEL=0 for CS_HOLD cycles, then SSEL=1 and go to GAP.
  - GAP: SSEL=1 for CS_IDLE cycles, then go to IDLE.
- tx_ready is 0 in every state except IDLE and NEXT. It drops in the cycle after a handshake.
- MISO sampling: the 2-FF synchroniser adds 2 clk latency. The sample point is end of HI, so slave response time must be below CLK_DIV+CLK_DIV-2 clk.
- Timing: single-byte message from handshake to SSEL rising = CS_SETUP + 16*CLK_DIV + CS_HOLD cycles (±1 registered).
- busy = SSEL low OR state==GAP.
- tx_valid held while tx_ready=0: ignored, no side effects.

Decomposition:
- Package spi_pkg: state enum (IDLE, SETUP, HI, LO, NEXT, HOLD, GAP); mode constants CPOL=0, CPHA=0.
- Sub-module spi_clkgen: half-period down-counter with load/terminal-count, shared across SETUP/HI/LO/HOLD/GAP.

Test Plan:
- Reset: hold rst 3 cycles during HI of a byte -> next cycle SCK=0, SSEL=1, tx_ready=0; IDLE (tx_ready=1) one cycle after release; no rx_valid.
- Single byte: send 0xA5 with last=1 against a model slave returning 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 valid at each SCK rise; rx_data=0x3C with one rx_valid pulse; SSEL low for 4+64+4 cycles at CLK_DIV=4.
- Multi-byte: send 0x01, 0x02, 0x03 with last on 0x03, tx_valid held continuously -> SSEL never rises between bytes; exactly 3 rx_valid pulses; 24 SCK rising edges.
- Back-pressure: in NEXT, keep tx_valid low for 100 cycles -> SSEL stays 0, SCK stays 0, tx_ready stays 1; resumes correctly on 0xFF.
- Gap: two back-to-back single-byte messages -> SSEL high ≥8 cycles between them; busy=1 throughout the gap.
- Divider edge: CLK_DIV=2, loopback MISO=MOSI, send 0x5A -> rx_data=0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

    // Controller states, in the order a message walks through them
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HI,
        LO,
        NEXT,
        HOLD,
        GAP
    } spi_state_t;

    // Mode 0: SCK idles low, data is sampled on the rising edge
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_master_if.sv
// Byte handshake and serial pins of the SPI master, bundled for port lists.
interface spi_master_if;
    import spi_pkg::*;

    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SSEL;

    modport master (
        input  tx_data, tx_last, tx_valid, MISO,
        output tx_ready, rx_data, rx_valid, busy, SCK, MOSI, SSEL
    );

    modport slave (
        output tx_data, tx_last, tx_valid, MISO,
        input  tx_ready, rx_data, rx_valid, busy, SCK, MOSI, SSEL
    );

endinterface

// File: rtl/spi_clkgen.sv
// Phase timer shared by every timed state: load N, terminal count after N cycles.
module spi_clkgen
    import spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tc
);

    logic [7:0] count;

    // Load wins; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val - 8'd1;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign tc = (count == 8'd0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: MSB-first 8-bit frames, messages framed by tx_last.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input logic        clk,
    input logic        rst,
    spi_master_if.master bus
);

    localparam logic [7:0] DIV_LEN   = 8'(CLK_DIV);
    localparam logic [7:0] SETUP_LEN = 8'(CS_SETUP);
    localparam logic [7:0] HOLD_LEN  = 8'(CS_HOLD);
    localparam logic [7:0] IDLE_LEN  = 8'(CS_IDLE);

    spi_state_t state;
    spi_state_t state_next;
    logic       cnt_load;
    logic [7:0] cnt_val;
    logic       tc;
    logic       handshake;
    logic [7:0] shreg;
    logic [7:0] rxreg;
    logic [7:0] rx_shifted;
    logic [2:0] bit_cnt;
    logic       last;
    logic       miso_meta;
    logic       miso_sync;

    assign handshake  = bus.tx_valid && bus.tx_ready;
    assign rx_shifted = {rxreg[6:0], miso_sync};

    spi_clkgen u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (tc)
    );

    // Next state and phase-timer reload; a byte accepted in NEXT reuses SETUP
    // with a LO-length count so MOSI gets a half period of setup before SCK rises
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_val    = DIV_LEN;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = SETUP;
                    cnt_load   = 1'b1;
                    cnt_val    = SETUP_LEN;
                end
            end
            SETUP: begin
                if (tc) begin
                    state_next = HI;
                    cnt_load   = 1'b1;
                end
            end
            HI: begin
                if (tc) begin
                    state_next = LO;
                    cnt_load   = 1'b1;
                end
            end
            LO: begin
                if (tc) begin
                    if (bit_cnt != 3'd7) begin
                        state_next = HI;
                        cnt_load   = 1'b1;
                    end else if (last) begin
                        state_next = HOLD;
                        cnt_load   = 1'b1;
                        cnt_val    = HOLD_LEN;
                    end else begin
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                if (handshake) begin
                    state_next = SETUP;
                    cnt_load   = 1'b1;
                end
            end
            HOLD: begin
                if (tc) begin
                    state_next = GAP;
                    cnt_load   = 1'b1;
                    cnt_val    = IDLE_LEN;
                end
            end
            GAP: begin
                if (tc) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pin-level outputs registered from the upcoming state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.SCK      <= CPOL;
            bus.SSEL     <= 1'b1;
            bus.tx_ready <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.SCK      <= (state_next == HI) ? ~CPOL : CPOL;
            bus.SSEL     <= (state_next inside {IDLE, GAP});
            bus.tx_ready <= (state_next inside {IDLE, NEXT});
            bus.busy     <= (state_next != IDLE);
        end
    end

    // Two-flop synchroniser for the asynchronous MISO pin
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= bus.MISO;
            miso_sync <= miso_meta;
        end
    end

    // Shift datapath: load on handshake, sample at end of HI, advance MOSI at LO entry
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            rxreg        <= '0;
            bit_cnt      <= '0;
            last         <= 1'b0;
            bus.MOSI     <= 1'b0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            if (handshake) begin
                shreg    <= bus.tx_data;
                last     <= bus.tx_last;
                bus.MOSI <= bus.tx_data[7];
                bit_cnt  <= '0;
            end
            if (state == HI && tc) begin
                rxreg <= rx_shifted;
                if (bit_cnt == 3'd7) begin
                    bus.rx_data  <= rx_shifted;
                    bus.rx_valid <= 1'b1;
                end else begin
                    shreg    <= {shreg[6:0], 1'b0};
                    bus.MOSI <= shreg[6];
                end
            end
            if (state == LO && tc) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule
